// File: rtl/alu8_sched_pkg.sv
// alu8_sched_pkg: shared opcodes, FSM states and flag positions for the ALU scheduler
package alu8_sched_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_NOT  = 4'hA;
  localparam logic [3:0] OP_LAST = 4'hA;
  localparam int FLG_C = 3;
  localparam int FLG_V = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 0;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu8_sched_alu8.sv
// alu8: combinational 8-bit ALU core with flags and error detection
module alu8
  import alu8_sched_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] op,
  output logic [7:0] result,
  output logic [3:0] flags,
  output logic       err
);
  logic [8:0] sum;
  logic [8:0] dif;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  // result mux; carry is the borrow for subtraction, carry/overflow only for add/sub
  always_comb begin
    case (op)
      OP_ADD:  result = sum[7:0];
      OP_SUB:  result = dif[7:0];
      OP_MUL:  result = a * b;
      OP_DIV:  result = (b == 8'd0) ? 8'd0 : a / b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_NOT:  result = ~a;
      default: result = 8'd0;
    endcase
    flags = 4'd0;
    flags[FLG_C] = (op == OP_ADD) ? sum[8] : (op == OP_SUB) ? dif[8] : 1'b0;
    flags[FLG_V] = (op == OP_ADD) ? (a[7] == b[7] && result[7] != a[7]) :
                   (op == OP_SUB) ? (a[7] != b[7] && result[7] != a[7]) : 1'b0;
    flags[FLG_Z] = (result == 8'd0);
    flags[FLG_N] = result[7];
    err = (op > OP_LAST) || (op == OP_DIV && b == 8'd0);
  end
endmodule

// File: rtl/alu8_sched.sv
// alu8_sched: two-requester arbiter sharing one alu8 core with a registered tagged response
module alu8_sched
  import alu8_sched_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [3:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [3:0] req1_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic [3:0] rsp_flags,
  output logic       rsp_err,
  output logic       busy
);
  state_t     state;
  state_t     state_nxt;
  logic       last_grant;
  logic       gnt;
  logic       window;
  logic       acc;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [3:0] op_op;
  logic       op_id;
  logic [7:0] alu_result;
  logic [3:0] alu_flags;
  logic       alu_err;
  // arbitration, ready generation and next state; a draining response reopens the accept window
  always_comb begin
    window = !rst && (state == IDLE || (state == RESP && rsp_ready));
    gnt = (req0_valid && req1_valid) ? (FAIR ? !last_grant : 1'b0) : req1_valid;
    req0_ready = window && req0_valid && !gnt;
    req1_ready = window && req1_valid && gnt;
    acc = req0_ready || req1_ready;
    state_nxt = IDLE;
    state_nxt = acc ? EXEC :
                (state == EXEC) ? RESP :
                (state == RESP && !rsp_ready) ? RESP : IDLE;
    busy = (state != IDLE);
  end
  // state register, grant history and operand capture on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (acc) begin
        last_grant <= gnt;
        op_id <= gnt;
        op_a <= gnt ? req1_a : req0_a;
        op_b <= gnt ? req1_b : req0_b;
        op_op <= gnt ? req1_op : req0_op;
      end
    end
  end
  // response registers load at the end of EXEC and hold until the consumer takes them
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_result <= 8'd0;
      rsp_flags <= 4'd0;
      rsp_err <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_id <= op_id;
      rsp_result <= alu_result;
      rsp_flags <= alu_flags;
      rsp_err <= alu_err;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
  alu8 u_alu (
    .a(op_a),
    .b(op_b),
    .op(op_op),
    .result(alu_result),
    .flags(alu_flags),
    .err(alu_err)
  );
endmodule

// File: tb/tb_alu8_sched.sv
// tb_alu8_sched: randomized and directed checks of alu8_sched against a behavioural model
module tb_alu8_sched;
  import alu8_sched_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [7:0] req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
  logic [3:0] req0_op = 4'd0, req1_op = 4'd0;
  logic r0_ready, r1_ready, rsp_valid, rsp_id, rsp_err, busy;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic p_r0_ready, p_r1_ready, p_rsp_valid, p_rsp_id, p_rsp_err, p_busy;
  logic [7:0] p_rsp_result;
  logic [3:0] p_rsp_flags;
  int total = 0;
  int bad = 0;
  logic mw, mg, me0, me1;
  logic m_exec = 1'b0, m_resp = 1'b0, m_last = 1'b1, m_id = 1'b0, m_eid = 1'b0;
  logic [7:0] m_a = 8'd0, m_b = 8'd0;
  logic [3:0] m_op = 4'd0;
  logic [12:0] m_exp = 13'd0;
  logic s_acc0 = 1'b0, s_acc1 = 1'b0;

  always #5 clk = ~clk;

  alu8_sched #(.FAIR(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(r0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(r1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
  );

  alu8_sched #(.FAIR(1'b0)) u_pri (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(p_r0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(p_r1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(p_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(p_rsp_id), .rsp_result(p_rsp_result),
    .rsp_flags(p_rsp_flags), .rsp_err(p_rsp_err), .busy(p_busy)
  );

  // {err, carry, overflow, zero, negative, result[7:0]} from plain integer arithmetic
  function automatic logic [12:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int r = 0;
    logic c = 1'b0;
    logic v = 1'b0;
    logic e;
    logic [7:0] res;
    case (op)
      4'h0: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      4'h1: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
      4'h2: r = ua * ub;
      4'h3: r = (ub == 0) ? 0 : ua / ub;
      4'h4: r = ua & ub;
      4'h5: r = ua | ub;
      4'h6: r = ~(ua & ub);
      4'h7: r = ~(ua | ub);
      4'h8: r = ua ^ ub;
      4'h9: r = ~(ua ^ ub);
      4'hA: r = ~ua;
      default: r = 0;
    endcase
    res = r[7:0];
    e = (op > 4'hA) || (op == 4'h3 && ub == 0);
    return {e, c, v, res == 8'd0, res[7], res};
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // negedge sample: compare the FAIR=1 DUT with the model, then advance the model past the next edge
  task automatic sample();
    @(negedge clk);
    if (rst) begin
      total++;
      if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
        bad++;
        $display("FAIL mon_rst_ready got=%b%b want=00", r0_ready, r1_ready);
      end
      m_exec = 1'b0; m_resp = 1'b0; m_last = 1'b1; s_acc0 = 1'b0; s_acc1 = 1'b0;
    end else begin
      mw = !m_exec && (!m_resp || rsp_ready);
      mg = (req0_valid && req1_valid) ? !m_last : req1_valid;
      me0 = mw && req0_valid && !mg;
      me1 = mw && req1_valid && mg;
      total++;
      if ({r0_ready, r1_ready} !== {me0, me1}) begin
        bad++;
        $display("FAIL mon_ready got=%b%b want=%b%b t=%0t", r0_ready, r1_ready, me0, me1, $time);
      end
      total++;
      if (rsp_valid !== m_resp || busy !== (m_exec || m_resp)) begin
        bad++;
        $display("FAIL mon_ctrl valid/busy got=%b/%b want=%b/%b t=%0t", rsp_valid, busy, m_resp, m_exec || m_resp, $time);
      end
      if (m_resp) begin
        total++;
        if ({rsp_id, rsp_err, rsp_flags, rsp_result} !== {m_eid, m_exp}) begin
          bad++;
          $display("FAIL mon_rsp got id=%b err=%b fl=%b res=%h want id=%b err=%b fl=%b res=%h t=%0t",
                   rsp_id, rsp_err, rsp_flags, rsp_result, m_eid, m_exp[12], m_exp[11:8], m_exp[7:0], $time);
        end
      end
      s_acc0 = me0;
      s_acc1 = me1;
      if (m_resp && rsp_ready) m_resp = 1'b0;
      if (m_exec) begin
        m_resp = 1'b1;
        m_exp = ref_alu(m_a, m_b, m_op);
        m_eid = m_id;
        m_exec = 1'b0;
      end
      if (me0 || me1) begin
        m_exec = 1'b1;
        m_last = mg;
        m_id = mg;
        m_a = mg ? req1_a : req0_a;
        m_b = mg ? req1_b : req0_b;
        m_op = mg ? req1_op : req0_op;
      end
    end
  endtask

  task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    bit got = 0;
    adv();
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
    else begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
    sample();
    for (int i = 0; i < 20 && !got; i++) begin
      if ((id ? r1_ready : r0_ready) === 1'b1) got = 1;
      else begin adv(); sample(); end
    end
    total++;
    if (!got) begin bad++; $display("FAIL issue_timeout id=%b got=no_ready want=ready", id); end
    adv();
    if (id) req1_valid = 0; else req0_valid = 0;
    sample();
  endtask

  task automatic wait_rsp();
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rsp_valid === 1'b1) got = 1;
      else begin adv(); sample(); end
    end
    total++;
    if (!got) begin bad++; $display("FAIL rsp_timeout got=no_rsp_valid want=rsp_valid"); end
  endtask

  task automatic test_reset();
    rst = 1; req0_valid = 1; req1_valid = 1; req0_op = 4'h0; req1_op = 4'h1;
    adv(); sample();
    adv(); sample();
    total++;
    if (rsp_valid !== 0 || rsp_id !== 0 || rsp_err !== 0 || busy !== 0) begin
      bad++; $display("FAIL reset_ctrl got v=%b id=%b err=%b busy=%b want all 0", rsp_valid, rsp_id, rsp_err, busy);
    end
    total++;
    if (rsp_result !== 8'd0 || rsp_flags !== 4'd0) begin
      bad++; $display("FAIL reset_data got res=%h fl=%b want 00/0000", rsp_result, rsp_flags);
    end
    total++;
    if ({p_rsp_valid, p_rsp_id, p_rsp_err, p_busy, p_rsp_result, p_rsp_flags, p_r0_ready, p_r1_ready} !== 18'd0) begin
      bad++; $display("FAIL reset_pri got v=%b id=%b err=%b busy=%b res=%h fl=%b rdy=%b%b want all 0",
                      p_rsp_valid, p_rsp_id, p_rsp_err, p_busy, p_rsp_result, p_rsp_flags, p_r0_ready, p_r1_ready);
    end
    adv(); rst = 0; req0_valid = 0; req1_valid = 0; sample();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy got=%b want=0", busy); end
  endtask

  task automatic test_add();
    rsp_ready = 1;
    adv(); req0_valid = 1; req0_a = 8'h7F; req0_b = 8'h01; req0_op = OP_ADD; sample();
    total++;
    if (r0_ready !== 1'b1) begin bad++; $display("FAIL add_accept req0_ready got=%b want=1", r0_ready); end
    adv(); req0_valid = 0; sample();
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL add_exec got v=%b busy=%b want 0/1", rsp_valid, busy);
    end
    adv(); sample();
    total++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result} !== {1'b1, 1'b0, 1'b0, 4'b0101, 8'h80}) begin
      bad++; $display("FAIL add_rsp got v=%b id=%b err=%b fl=%b res=%h want 1/0/0/0101/80",
                      rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result);
    end
    adv(); sample();
  endtask

  task automatic test_errors();
    rsp_ready = 1;
    issue(1'b1, 8'd9, 8'd0, OP_DIV);
    wait_rsp();
    total++;
    if ({rsp_id, rsp_err, rsp_flags, rsp_result} !== {1'b1, 1'b1, 4'b0010, 8'h00}) begin
      bad++; $display("FAIL div0 got id=%b err=%b fl=%b res=%h want 1/1/0010/00", rsp_id, rsp_err, rsp_flags, rsp_result);
    end
    adv(); sample();
    issue(1'b0, 8'h55, 8'h12, 4'hC);
    wait_rsp();
    total++;
    if ({rsp_id, rsp_err, rsp_flags, rsp_result} !== {1'b0, 1'b1, 4'b0010, 8'h00}) begin
      bad++; $display("FAIL illegal_op got id=%b err=%b fl=%b res=%h want 0/1/0010/00", rsp_id, rsp_err, rsp_flags, rsp_result);
    end
    adv(); sample();
  endtask

  task automatic test_backpressure();
    rsp_ready = 0;
    issue(1'b0, 8'h10, 8'h20, OP_ADD);
    wait_rsp();
    adv(); req0_valid = 1; req0_a = 8'd5; req0_b = 8'd3; req0_op = OP_SUB; sample();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_result !== 8'h30 || rsp_flags !== 4'b0000 || r0_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%b res=%h fl=%b rdy=%b want 1/30/0000/0",
                        i, rsp_valid, rsp_result, rsp_flags, r0_ready);
      end
      adv();
      if (i == 4) rsp_ready = 1;
      sample();
    end
    total++;
    if (r0_ready !== 1'b1 || rsp_valid !== 1'b1) begin
      bad++; $display("FAIL bp_release got rdy=%b v=%b want 1/1", r0_ready, rsp_valid);
    end
    adv(); req0_valid = 0; sample();
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_gap rsp_valid got=%b want=0", rsp_valid); end
    adv(); sample();
    total++;
    if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 8'h02}) begin
      bad++; $display("FAIL bp_next got v=%b id=%b res=%h want 1/0/02", rsp_valid, rsp_id, rsp_result);
    end
    adv(); sample();
  endtask

  task automatic test_reset_exec();
    rsp_ready = 1;
    adv(); req1_valid = 1; req1_a = 8'h33; req1_b = 8'h44; req1_op = OP_ADD; sample();
    total++;
    if (r1_ready !== 1'b1) begin bad++; $display("FAIL rx_accept req1_ready got=%b want=1", r1_ready); end
    adv(); req1_valid = 0; rst = 1; sample();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rx_exec busy got=%b want=1", busy); end
    adv(); rst = 0; sample();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL rx_dropped cyc=%0d got v=%b busy=%b want 0/0", i, rsp_valid, busy);
      end
      adv(); sample();
    end
    issue(1'b0, 8'h00, 8'h01, OP_SUB);
    wait_rsp();
    total++;
    if ({rsp_id, rsp_err, rsp_flags, rsp_result} !== {1'b0, 1'b0, 4'b1001, 8'hFF}) begin
      bad++; $display("FAIL sub_borrow got id=%b err=%b fl=%b res=%h want 0/0/1001/ff", rsp_id, rsp_err, rsp_flags, rsp_result);
    end
    adv(); sample();
  endtask

  task automatic test_fair();
    int cyc[$];
    logic ids[$];
    test_reset();
    rsp_ready = 1;
    for (int i = 0; i < 20; i++) begin
      adv();
      if (i == 0 || s_acc0) begin req0_valid = 1; req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 4'($urandom_range(0, 10)); end
      if (i == 0 || s_acc1) begin req1_valid = 1; req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 4'($urandom_range(0, 10)); end
      sample();
      if (r0_ready || r1_ready) begin cyc.push_back(i); ids.push_back(r1_ready); end
      total++;
      if (p_r1_ready !== 1'b0) begin bad++; $display("FAIL pri_grant req1_ready got=%b want=0 cyc=%0d", p_r1_ready, i); end
      if (p_rsp_valid) begin
        total++;
        if (p_rsp_id !== 1'b0) begin bad++; $display("FAIL pri_rsp_id got=%b want=0 cyc=%0d", p_rsp_id, i); end
      end
    end
    total++;
    if (cyc.size() != 10) begin bad++; $display("FAIL fair_count got=%0d want=10", cyc.size()); end
    if (ids.size() > 0) begin
      total++;
      if (ids[0] !== 1'b0) begin bad++; $display("FAIL fair_first got=%b want=0", ids[0]); end
    end
    for (int k = 1; k < cyc.size(); k++) begin
      total++;
      if (cyc[k] - cyc[k-1] != 2 || ids[k] === ids[k-1]) begin
        bad++; $display("FAIL fair_alt k=%0d got gap=%0d id=%b want gap=2 id=%b", k, cyc[k] - cyc[k-1], ids[k], !ids[k-1]);
      end
    end
    adv(); req0_valid = 0; req1_valid = 0; sample();
    adv(); sample();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      adv();
      if (!req0_valid || s_acc0) begin
        req0_valid = 1'($urandom); req0_a = 8'($urandom); req0_op = 4'($urandom);
        req0_b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      end else if ($urandom_range(0, 7) == 0) req0_valid = 0;
      if (!req1_valid || s_acc1) begin
        req1_valid = 1'($urandom); req1_a = 8'($urandom); req1_op = 4'($urandom);
        req1_b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      end else if ($urandom_range(0, 7) == 0) req1_valid = 0;
      rsp_ready = ($urandom_range(0, 3) != 0);
      sample();
    end
    adv(); req0_valid = 0; req1_valid = 0; rsp_ready = 1; sample();
    for (int i = 0; i < 4; i++) begin adv(); sample(); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rand_drain busy got=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_errors();
    test_backpressure();
    test_reset_exec();
    test_fair();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
